johnson_decoder: RTL and testbench
==================================

Name: johnson_decoder

Overview:
Receiver-side companion to the team's Johnson (twisted-ring) counter. Samples a Johnson-coded word and produces:
- binary state index and one-hot state
- legality check for the code word
- sequence-continuity check (+1 step modulo 2*WIDTH)
- lock state machine and sticky error flag
Sits downstream of any Johnson counter, or a Johnson-coded bus crossing a boundary, as a monitor/decoder.

Parameters:
WIDTH, 4, Johnson word width; legal range >= 2; number of states = 2*WIDTH.
SHIFT_LEFT, 1'b1, 1 = classic left-shift code (0000->0001->0011...); 0 = mirror right-shift code (0000->1000->1100...).
LOCK_COUNT, 4, consecutive legal, in-sequence samples needed to assert locked; legal range >= 1.
IDX_W, $clog2(2*WIDTH), derived index width; not for override.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
johnson_in  input  WIDTH  Johnson-coded sample
in_valid  input  1  johnson_in is sampled this cycle
clr_err  input  1  clears sticky_err
index  output  IDX_W  decoded state index 0..2*WIDTH-1
onehot  output  2*WIDTH  one-hot of index
out_valid  output  1  index/onehot updated from a legal sample (1-cycle pulse)
illegal  output  1  1-cycle pulse: sampled word is not a Johnson code
seq_err  output  1  1-cycle pulse: step other than +1 while locked
locked  output  1  lock state machine is in LOCKED
sticky_err  output  1  latched illegal|seq_err
err_count  output  16  saturating error count (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM = UNLOCKED; acq_cnt = 0; prev_idx = 0.
- Latency: one clock. A sample with in_valid=1 at edge N drives index, onehot, out_valid, illegal, seq_err, locked at edge N+1.
- in_valid=0: no state change; out_valid, illegal and seq_err = 0; index and onehot hold.
- Legality: word is legal iff it has at most one position i with bit[i] != bit[i+1]. All-zero and all-one words are legal.
- Index, SHIFT_LEFT=1: msb=0 -> popcount; msb=1 -> 2*WIDTH - popcount.
- Index, SHIFT_LEFT=0: same rule with lsb as the discriminator bit.
- Legal sample: out_valid=1; index and onehot updated.
- Illegal sample: out_valid=0; illegal=1; index and onehot hold.
- Step check: expected = (prev_idx+1) mod 2*WIDTH. Wrap 2*WIDTH-1 -> 0 is a correct step. Hold (same index) counts as a mismatch.
- FSM on a valid sample:
  - UNLOCKED: legal -> ACQUIRE, acq_cnt=1. If LOCK_COUNT=1, go directly to LOCKED.
  - ACQUIRE, legal and correct step: acq_cnt++; on reaching LOCK_COUNT -> LOCKED.
  - ACQUIRE, legal but wrong step: stay in ACQUIRE, acq_cnt=1. No seq_err.
  - ACQUIRE, illegal: -> UNLOCKED.
  - LOCKED, correct step: stay in LOCKED.
  - LOCKED, legal wrong step: seq_err=1, -> ACQUIRE, acq_cnt=1.
  - LOCKED, illegal: illegal=1, -> UNLOCKED.
- prev_idx updates on every legal sample.
- locked = (state == LOCKED), registered with the other outputs.
- sticky_err: set by illegal|seq_err and cleared by clr_err. Set wins when both occur in the same cycle.
- Reset mid-operation returns to reset state on the next edge, regardless of in_valid.

Optional Feature:
JOHNSON_DEC_ERR_CNT_EN
- Defined: err_count increments by 1 on each illegal or seq_err pulse, saturates at 16'hFFFF, and clears on reset or clr_err. Same-cycle clear plus error gives 1.
- Undefined: err_count tied to 0; no counter flops.

Decomposition:
- Package johnson_pkg:
  - state enum {UNLOCKED, ACQUIRE, LOCKED}
  - popcount function
  - function returning index width for a given WIDTH
- Sub-module johnson_code_decode: purely combinational. Takes WIDTH and SHIFT_LEFT; inputs the word; outputs legal and index.

Test Plan:
1. WIDTH=4, SHIFT_LEFT=1, LOCK_COUNT=4: samples 0000,0001,0011,0111 on consecutive cycles -> index 0,1,2,3 one cycle later; out_valid each cycle; locked rises with index=3.
2. Locked, samples 1100,1000,0000 -> index 6,7,0; no seq_err on wrap; locked stays 1.
3. Locked, sample 0101 -> illegal=1, out_valid=0, index holds, locked=0, sticky_err=1; then clr_err -> sticky_err=0.
4. Locked at index 2 (0011), sample 1111 -> index 4, seq_err=1, locked=0. Then 1110,1100,1000 -> locked re-asserts with index=7 (4 samples counting 1111).
5. Same cycle as clr_err, inject illegal 1010 -> sticky_err stays 1. Assert reset while locked -> all outputs 0 next edge.
6. SHIFT_LEFT=0: samples 1000 -> index 1; 0111 -> index 5. With JOHNSON_DEC_ERR_CNT_EN, three illegal samples -> err_count=3.

Source files
------------

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and helpers for the Johnson-code decoder
package johnson_pkg;

    // Widest Johnson word the popcount helper accepts.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // Number of set bits in a word; narrower words are zero-extended by the caller.
    function automatic int popcount(input logic [MAX_WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    // Index width needed to number the 2*w states of a w-bit Johnson code.
    function automatic int idx_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// rtl/johnson_code_decode.sv - combinational Johnson word legality check and index decode
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter bit   SHIFT_LEFT = 1'b1,
    localparam int  IDX_W      = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    output logic             legal,
    output logic [IDX_W-1:0] index
);

    logic [MAX_WIDTH-1:0] word_ext;
    logic                 disc;
    int                   transitions;
    int                   ones;
    int                   raw;

    // A Johnson word has at most one boundary between its run of ones and run of zeros;
    // the bit that enters first tells whether we are in the filling or draining half.
    always_comb begin
        word_ext            = '0;
        word_ext[WIDTH-1:0] = word;
        transitions         = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            transitions = transitions + int'(word[i] ^ word[i+1]);
        end
        disc  = SHIFT_LEFT ? word[WIDTH-1] : word[0];
        ones  = popcount(word_ext);
        raw   = disc ? (2 * WIDTH - ones) : ones;
        legal = (transitions <= 1);
        index = IDX_W'(raw);
    end

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson-code monitor: index/one-hot decode, step check, lock FSM; JOHNSON_DEC_ERR_CNT_EN adds the error counter
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter bit   SHIFT_LEFT = 1'b1,
    parameter int   LOCK_COUNT = 4,
    localparam int  IDX_W      = idx_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     johnson_in,
    input  logic                 in_valid,
    input  logic                 clr_err,
    output logic [IDX_W-1:0]     index,
    output logic [2*WIDTH-1:0]   onehot,
    output logic                 out_valid,
    output logic                 illegal,
    output logic                 seq_err,
    output logic                 locked,
    output logic                 sticky_err,
    output logic [15:0]          err_count
);

    localparam int NSTATES = 2 * WIDTH;
    localparam int ACQ_W   = $clog2(LOCK_COUNT + 1);

    state_t             state_q, state_d;
    logic [ACQ_W-1:0]   acq_cnt_q, acq_cnt_d;
    logic [IDX_W-1:0]   prev_idx_q;
    logic [IDX_W-1:0]   index_q;
    logic [NSTATES-1:0] onehot_q;
    logic               out_valid_q, illegal_q, seq_err_q, sticky_q;

    logic               dec_legal;
    logic [IDX_W-1:0]   dec_index;
    logic [IDX_W-1:0]   exp_idx;
    logic               step_ok;
    logic               out_valid_d, illegal_d, seq_err_d, sticky_d;

    johnson_code_decode #(
        .WIDTH      (WIDTH),
        .SHIFT_LEFT (SHIFT_LEFT)
    ) u_decode (
        .word  (johnson_in),
        .legal (dec_legal),
        .index (dec_index)
    );

    // The last state wraps back to zero, which is a normal forward step.
    assign exp_idx = (prev_idx_q == IDX_W'(NSTATES - 1)) ? '0 : prev_idx_q + IDX_W'(1);
    assign step_ok = (dec_index == exp_idx);

    // Lock state register and acquisition counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= UNLOCKED;
            acq_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acq_cnt_q <= acq_cnt_d;
        end
    end

    // Lock progression: count consecutive in-sequence legal samples, fall back on any break.
    always_comb begin
        state_d   = state_q;
        acq_cnt_d = acq_cnt_q;
        if (in_valid) begin
            case (state_q)
                UNLOCKED: begin
                    if (dec_legal) begin
                        state_d   = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
                        acq_cnt_d = ACQ_W'(1);
                    end
                end
                ACQUIRE: begin
                    if (!dec_legal) begin
                        state_d   = UNLOCKED;
                        acq_cnt_d = '0;
                    end else if (step_ok) begin
                        acq_cnt_d = acq_cnt_q + ACQ_W'(1);
                        if ((acq_cnt_q + ACQ_W'(1)) >= ACQ_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        acq_cnt_d = ACQ_W'(1);
                    end
                end
                LOCKED: begin
                    if (!dec_legal) begin
                        state_d   = UNLOCKED;
                        acq_cnt_d = '0;
                    end else if (!step_ok) begin
                        state_d   = ACQUIRE;
                        acq_cnt_d = ACQ_W'(1);
                    end
                end
                default: begin
                    state_d   = UNLOCKED;
                    acq_cnt_d = '0;
                end
            endcase
        end
    end

    // Per-sample pulses; a new error outranks a same-cycle clear of the sticky flag.
    always_comb begin
        out_valid_d = in_valid & dec_legal;
        illegal_d   = in_valid & ~dec_legal;
        seq_err_d   = in_valid & dec_legal & ~step_ok & (state_q == LOCKED);
        sticky_d    = sticky_q;
        if (illegal_d | seq_err_d) begin
            sticky_d = 1'b1;
        end else if (clr_err) begin
            sticky_d = 1'b0;
        end
    end

    // Registered outputs; index, one-hot and step reference only move on legal samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            sticky_q    <= 1'b0;
            index_q     <= '0;
            onehot_q    <= '0;
            prev_idx_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            sticky_q    <= sticky_d;
            if (out_valid_d) begin
                index_q    <= dec_index;
                onehot_q   <= NSTATES'(1) << dec_index;
                prev_idx_q <= dec_index;
            end
        end
    end

`ifdef JOHNSON_DEC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating error tally; an error arriving with a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (illegal_d | seq_err_d) begin
            if (clr_err) begin
                err_cnt_q <= 16'd1;
            end else if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end else if (clr_err) begin
            err_cnt_q <= '0;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

    assign index      = index_q;
    assign onehot     = onehot_q;
    assign out_valid  = out_valid_q;
    assign illegal    = illegal_q;
    assign seq_err    = seq_err_q;
    assign locked     = (state_q == LOCKED);
    assign sticky_err = sticky_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - table-driven checks of johnson_decoder, left- and right-shift builds
module tb_johnson_decoder;

    logic        clk;
    logic        reset;

    logic [3:0]  l_word;
    logic        l_valid;
    logic        l_clr;
    logic [2:0]  l_index;
    logic [7:0]  l_onehot;
    logic        l_out_valid, l_illegal, l_seq_err, l_locked, l_sticky;
    logic [15:0] l_err_count;

    logic [3:0]  r_word;
    logic        r_valid;
    logic        r_clr;
    logic [2:0]  r_index;
    logic [7:0]  r_onehot;
    logic        r_out_valid, r_illegal, r_seq_err, r_locked, r_sticky;
    logic [15:0] r_err_count;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    johnson_decoder #(.WIDTH(4), .SHIFT_LEFT(1'b1), .LOCK_COUNT(4)) dut_l (
        .clk        (clk),
        .reset      (reset),
        .johnson_in (l_word),
        .in_valid   (l_valid),
        .clr_err    (l_clr),
        .index      (l_index),
        .onehot     (l_onehot),
        .out_valid  (l_out_valid),
        .illegal    (l_illegal),
        .seq_err    (l_seq_err),
        .locked     (l_locked),
        .sticky_err (l_sticky),
        .err_count  (l_err_count)
    );

    johnson_decoder #(.WIDTH(4), .SHIFT_LEFT(1'b0), .LOCK_COUNT(4)) dut_r (
        .clk        (clk),
        .reset      (reset),
        .johnson_in (r_word),
        .in_valid   (r_valid),
        .clr_err    (r_clr),
        .index      (r_index),
        .onehot     (r_onehot),
        .out_valid  (r_out_valid),
        .illegal    (r_illegal),
        .seq_err    (r_seq_err),
        .locked     (r_locked),
        .sticky_err (r_sticky),
        .err_count  (r_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] w;
        logic       clr;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       ov;
        logic       ill;
        logic       se;
        logic       lk;
        logic       st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [3:0] w, input logic clr,
                                input logic [2:0] idx, input logic [7:0] oh, input logic ov,
                                input logic ill, input logic se, input logic lk, input logic st);
        vec_t t;
        t.v = v; t.w = w; t.clr = clr; t.idx = idx; t.oh = oh;
        t.ov = ov; t.ill = ill; t.se = se; t.lk = lk; t.st = st;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cnt_exp(input int n);
`ifdef JOHNSON_DEC_ERR_CNT_EN
        return 16'(n);
`else
        return 16'd0 & 16'(n);
`endif
    endfunction

    task automatic check_l_zero(input string tag);
        check({tag, " index"},     32'(l_index),     32'd0);
        check({tag, " onehot"},    32'(l_onehot),    32'd0);
        check({tag, " out_valid"}, 32'(l_out_valid), 32'd0);
        check({tag, " illegal"},   32'(l_illegal),   32'd0);
        check({tag, " seq_err"},   32'(l_seq_err),   32'd0);
        check({tag, " locked"},    32'(l_locked),    32'd0);
        check({tag, " sticky"},    32'(l_sticky),    32'd0);
        check({tag, " err_count"}, 32'(l_err_count), 32'd0);
    endtask

    task automatic r_step(input logic v, input logic [3:0] w);
        r_valid = v;
        r_word  = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        l_word  = 4'b0000; l_valid = 1'b0; l_clr = 1'b0;
        r_word  = 4'b0000; r_valid = 1'b0; r_clr = 1'b0;

        //       v  word     clr idx  onehot  ov ill se lk st
        // acquire and lock on 0,1,2,3
        tbl.push_back(mk(1, 4'b0000, 0, 3'd0, 8'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 0, 3'd1, 8'h02, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 0, 3'd2, 8'h04, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0111, 0, 3'd3, 8'h08, 1, 0, 0, 1, 0));
        // idle cycle holds index
        tbl.push_back(mk(0, 4'b0101, 0, 3'd3, 8'h08, 0, 0, 0, 1, 0));
        // run through the draining half and wrap 7 -> 0
        tbl.push_back(mk(1, 4'b1111, 0, 3'd4, 8'h10, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b1110, 0, 3'd5, 8'h20, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b1100, 0, 3'd6, 8'h40, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b1000, 0, 3'd7, 8'h80, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 3'd0, 8'h01, 1, 0, 0, 1, 0));
        // illegal while locked, then clear
        tbl.push_back(mk(1, 4'b0101, 0, 3'd0, 8'h01, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 3'd0, 8'h01, 0, 0, 0, 0, 0));
        // relock at index 2
        tbl.push_back(mk(1, 4'b1000, 0, 3'd7, 8'h80, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 3'd0, 8'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 0, 3'd1, 8'h02, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 0, 3'd2, 8'h04, 1, 0, 0, 1, 0));
        // jump 2 -> 4 while locked, then relock on 4 samples
        tbl.push_back(mk(1, 4'b1111, 0, 3'd4, 8'h10, 1, 0, 1, 0, 1));
        tbl.push_back(mk(1, 4'b1110, 0, 3'd5, 8'h20, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b1100, 0, 3'd6, 8'h40, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 3'd7, 8'h80, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 3'd7, 8'h80, 0, 0, 0, 1, 0));
        // clear and illegal in the same cycle: set wins
        tbl.push_back(mk(1, 4'b1010, 1, 3'd7, 8'h80, 0, 1, 0, 0, 1));
        // wrong step during acquire restarts the count without seq_err
        tbl.push_back(mk(1, 4'b0000, 0, 3'd0, 8'h01, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0011, 0, 3'd2, 8'h04, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0111, 0, 3'd3, 8'h08, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 0, 3'd4, 8'h10, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b1110, 0, 3'd5, 8'h20, 1, 0, 0, 1, 1));
        // repeated index while locked is a step error
        tbl.push_back(mk(1, 4'b1110, 0, 3'd5, 8'h20, 1, 0, 1, 0, 1));
        // illegal during acquire drops to unlocked; four fresh samples needed
        tbl.push_back(mk(1, 4'b1101, 0, 3'd5, 8'h20, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'b1100, 0, 3'd6, 8'h40, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 3'd7, 8'h80, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 3'd0, 8'h01, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0001, 0, 3'd1, 8'h02, 1, 0, 0, 1, 1));

        @(posedge clk);
        @(posedge clk);
        #1;
        check_l_zero("reset");
        check("reset r locked", 32'(r_locked), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            l_valid = tbl[i].v;
            l_word  = tbl[i].w;
            l_clr   = tbl[i].clr;
            @(posedge clk);
            #1;
            if (tbl[i].clr) exp_err = 0;
            if (tbl[i].ill | tbl[i].se) exp_err++;
            check($sformatf("v%0d index", i),     32'(l_index),     32'(tbl[i].idx));
            check($sformatf("v%0d onehot", i),    32'(l_onehot),    32'(tbl[i].oh));
            check($sformatf("v%0d out_valid", i), 32'(l_out_valid), 32'(tbl[i].ov));
            check($sformatf("v%0d illegal", i),   32'(l_illegal),   32'(tbl[i].ill));
            check($sformatf("v%0d seq_err", i),   32'(l_seq_err),   32'(tbl[i].se));
            check($sformatf("v%0d locked", i),    32'(l_locked),    32'(tbl[i].lk));
            check($sformatf("v%0d sticky", i),    32'(l_sticky),    32'(tbl[i].st));
            check($sformatf("v%0d err_count", i), 32'(l_err_count), 32'(cnt_exp(exp_err)));
        end

        // reset while locked with a valid sample present
        l_valid = 1'b1;
        l_word  = 4'b0011;
        l_clr   = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        check_l_zero("midreset");
        reset   = 1'b0;
        l_valid = 1'b0;

        // right-shift code decode
        r_step(1'b1, 4'b0000);
        check("r 0000 index", 32'(r_index), 32'd0);
        check("r 0000 valid", 32'(r_out_valid), 32'd1);
        r_step(1'b1, 4'b1000);
        check("r 1000 index", 32'(r_index), 32'd1);
        check("r 1000 onehot", 32'(r_onehot), 32'h02);
        r_step(1'b1, 4'b1100);
        check("r 1100 index", 32'(r_index), 32'd2);
        r_step(1'b1, 4'b1111);
        check("r 1111 index", 32'(r_index), 32'd4);
        check("r 1111 seq_err", 32'(r_seq_err), 32'd0);
        r_step(1'b1, 4'b0111);
        check("r 0111 index", 32'(r_index), 32'd5);
        check("r 0111 onehot", 32'(r_onehot), 32'h20);
        check("r 0111 illegal", 32'(r_illegal), 32'd0);

        // three illegal samples accumulate in the error counter
        r_step(1'b1, 4'b0101);
        check("r ill1 illegal", 32'(r_illegal), 32'd1);
        r_step(1'b1, 4'b1010);
        r_step(1'b1, 4'b0110);
        check("r ill3 illegal", 32'(r_illegal), 32'd1);
        check("r ill3 index", 32'(r_index), 32'd5);
        check("r ill3 sticky", 32'(r_sticky), 32'd1);
        check("r ill3 err_count", 32'(r_err_count), 32'(cnt_exp(3)));
        r_step(1'b0, 4'b0000);
        check("r idle illegal", 32'(r_illegal), 32'd0);
        check("r idle err_count", 32'(r_err_count), 32'(cnt_exp(3)));
        r_clr = 1'b1;
        r_step(1'b0, 4'b0000);
        r_clr = 1'b0;
        check("r clr sticky", 32'(r_sticky), 32'd0);
        check("r clr err_count", 32'(r_err_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
